// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Entries are {pc, instr}. The PC advances by one 32-bit word per fetch.
package fetch_queue_unit_pkg;

    localparam int FETCH_PC_W  = 9;
    localparam int FETCH_INS_W = 32;
    localparam int PC_STEP     = 4;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]  pc;
        logic [FETCH_INS_W-1:0] instr;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Bundles the imem, ID-handshake, redirect and halt signals of the fetch unit.
// The slave modport is the fetch unit; the master modport is its environment.
interface fetch_queue_unit_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32,
    parameter int CNT_W = 3
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_rdata;
    logic             id_valid;
    logic             id_ready;
    logic [INS_W-1:0] id_instr;
    logic [PC_W-1:0]  id_pc;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             halt_req;
    logic             halted;
    logic [CNT_W-1:0] queue_count;

    modport slave (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, halted, queue_count,
        input  imem_rdata, id_ready, redirect_valid, redirect_pc, halt_req
    );

    modport master (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, halted, queue_count,
        output imem_rdata, id_ready, redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Circular buffer holding fetched {pc, instr} entries between imem and ID.
// Clear drops all entries in one cycle and overrides push/pop.
module fetch_queue_unit_fifo #(
    parameter int W     = 41,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    input  logic             clear,
    output logic [W-1:0]     dout,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (!reset && !clear && push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign valid = (count != '0);

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle imem reads,
// queues returned words for ID, and handles EX redirects and a sticky halt.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter int              INS_W    = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = PC_W + INS_W;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  inflight_pc;
    logic             inflight;
    logic             halt_latched;
    logic             issue;
    logic             enq;
    logic             deq;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W-1:0] count;
    logic             head_valid;
    logic [ENT_W-1:0] head;

    // Credit counts the in-flight word so a returning fetch always has a slot.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

    assign issue = !reset && !halt_latched && !bus.halt_req && !bus.redirect_valid
                   && (credit_used < (CNT_W+1)'(DEPTH));

    assign enq = inflight && !bus.redirect_valid;
    assign deq = head_valid && bus.id_ready && !bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= '0;
            halt_latched <= 1'b0;
        end else begin
            if (bus.halt_req) halt_latched <= 1'b1;
            if (bus.redirect_valid)
                fetch_pc <= bus.redirect_pc;
            else if (issue)
                fetch_pc <= fetch_pc + PC_W'(PC_STEP);
            inflight <= issue;
            if (issue) inflight_pc <= fetch_pc;
        end
    end

    fetch_queue_unit_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (enq),
        .din   ({inflight_pc, bus.imem_rdata}),
        .pop   (deq),
        .clear (bus.redirect_valid),
        .dout  (head),
        .valid (head_valid),
        .count (count)
    );

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.id_valid    = head_valid;
    assign bus.id_pc       = head[ENT_W-1:INS_W];
    assign bus.id_instr    = head[INS_W-1:0];
    assign bus.halted      = halt_latched && !inflight;
    assign bus.queue_count = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed cycle-by-cycle bench for fetch_queue_unit with a 1-cycle imem model
// driven from the stimulus process; instruction words are tagged with their address.
module tb_fetch_queue_unit;

    localparam int PC_W  = 9;
    localparam int INS_W = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    fetch_queue_unit_if #(.PC_W(PC_W), .INS_W(INS_W), .CNT_W(CNT_W)) bus ();

    fetch_queue_unit #(
        .PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input int a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Advance one clock; imem answers the request seen just before the edge.
    task automatic next_cycle();
        logic            r;
        logic [PC_W-1:0] a;
        r = bus.imem_req;
        a = bus.imem_addr;
        @(posedge clk);
        #1;
        bus.imem_rdata = (r === 1'b1) ? tag(int'(a)) : 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.imem_rdata = '0;
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.halt_req = 1'b0;

        next_cycle();
        #1;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", bus.id_valid, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_count", bus.queue_count, 0);
        next_cycle();

        // Streaming after reset release
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("t1_req_c%0d", k), bus.imem_req, 1);
            chk($sformatf("t1_addr_c%0d", k), bus.imem_addr, 4 * (k - 1));
            if (k >= 3) begin
                chk($sformatf("t1_valid_c%0d", k), bus.id_valid, 1);
                chk($sformatf("t1_pc_c%0d", k), bus.id_pc, 4 * (k - 3));
                chk($sformatf("t1_instr_c%0d", k), bus.id_instr, tag(4 * (k - 3)));
            end else begin
                chk($sformatf("t1_valid_c%0d", k), bus.id_valid, 0);
            end
            next_cycle();
        end

        // ID stall: queue fills, fetch stops, head held
        bus.id_ready = 1'b0;
        for (int k = 7; k <= 16; k++) begin
            #1;
            chk($sformatf("t2_valid_c%0d", k), bus.id_valid, 1);
            chk($sformatf("t2_pc_c%0d", k), bus.id_pc, 'h10);
            chk($sformatf("t2_instr_c%0d", k), bus.id_instr, tag('h10));
            chk($sformatf("t2_count_c%0d", k), bus.queue_count, (k - 6 < 4) ? k - 6 : 4);
            chk($sformatf("t2_req_c%0d", k), bus.imem_req, (k <= 8) ? 1 : 0);
            next_cycle();
        end
        bus.id_ready = 1'b1;
        for (int k = 17; k <= 20; k++) begin
            #1;
            chk($sformatf("t2_drain_pc_c%0d", k), bus.id_pc, 'h10 + 4 * (k - 17));
            chk($sformatf("t2_drain_count_c%0d", k), bus.queue_count,
                (k == 17) ? 4 : ((k == 18) ? 3 : 2));
            chk($sformatf("t2_drain_req_c%0d", k), bus.imem_req, (k == 17) ? 0 : 1);
            if (k > 17)
                chk($sformatf("t2_drain_addr_c%0d", k), bus.imem_addr, 'h20 + 4 * (k - 18));
            next_cycle();
        end

        // Redirect with 3 queued + 1 in flight
        bus.id_ready = 1'b0;
        #1;
        chk("t3_pre_pc", bus.id_pc, 'h20);
        chk("t3_pre_count", bus.queue_count, 2);
        chk("t3_pre_addr", bus.imem_addr, 'h2C);
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h040;
        #1;
        chk("t3_redir_req", bus.imem_req, 0);
        chk("t3_redir_count", bus.queue_count, 3);
        next_cycle();
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        chk("t3_r1_valid", bus.id_valid, 0);
        chk("t3_r1_count", bus.queue_count, 0);
        chk("t3_r1_req", bus.imem_req, 1);
        chk("t3_r1_addr", bus.imem_addr, 'h40);
        next_cycle();
        #1;
        chk("t3_r2_valid", bus.id_valid, 0);
        chk("t3_r2_addr", bus.imem_addr, 'h44);
        next_cycle();
        #1;
        chk("t3_r3_valid", bus.id_valid, 1);
        chk("t3_r3_pc", bus.id_pc, 'h40);
        chk("t3_r3_instr", bus.id_instr, tag('h40));
        chk("t3_r3_addr", bus.imem_addr, 'h48);
        next_cycle();

        // Redirect to the top of the PC space; fetch wraps
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h1FC;
        #1;
        chk("t5_redir_pc", bus.id_pc, 'h44);
        chk("t5_redir_req", bus.imem_req, 0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t5_w0_addr", bus.imem_addr, 'h1FC);
        chk("t5_w0_valid", bus.id_valid, 0);
        next_cycle();
        #1;
        chk("t5_w1_addr", bus.imem_addr, 'h000);
        chk("t5_w1_valid", bus.id_valid, 0);
        next_cycle();
        #1;
        chk("t5_w2_addr", bus.imem_addr, 'h004);
        chk("t5_w2_pc", bus.id_pc, 'h1FC);
        next_cycle();
        #1;
        chk("t5_w3_addr", bus.imem_addr, 'h008);
        chk("t5_w3_pc", bus.id_pc, 'h000);
        next_cycle();
        #1;
        chk("t5_w4_addr", bus.imem_addr, 'h00C);
        chk("t5_w4_pc", bus.id_pc, 'h004);
        next_cycle();

        // Reset with queue loaded and a fetch in flight
        bus.id_ready = 1'b0;
        #1;
        next_cycle();
        #1;
        chk("t6_pre_count", bus.queue_count, 2);
        chk("t6_pre_addr", bus.imem_addr, 'h14);
        next_cycle();
        reset = 1'b1;
        #1;
        chk("t6_rst_count_before", bus.queue_count, 3);
        chk("t6_rst_pc_before", bus.id_pc, 'h008);
        chk("t6_rst_req", bus.imem_req, 0);
        next_cycle();
        #1;
        chk("t6_after_req", bus.imem_req, 0);
        chk("t6_after_valid", bus.id_valid, 0);
        chk("t6_after_count", bus.queue_count, 0);
        chk("t6_after_halted", bus.halted, 0);
        next_cycle();
        reset = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        chk("t6_re0_addr", bus.imem_addr, 0);
        chk("t6_re0_req", bus.imem_req, 1);
        chk("t6_re0_valid", bus.id_valid, 0);
        next_cycle();
        #1;
        chk("t6_re1_addr", bus.imem_addr, 4);
        chk("t6_re1_valid", bus.id_valid, 0);
        next_cycle();
        #1;
        chk("t6_re2_addr", bus.imem_addr, 8);
        chk("t6_re2_pc", bus.id_pc, 0);
        chk("t6_re2_instr", bus.id_instr, tag(0));
        next_cycle();
        #1;
        chk("t6_re3_addr", bus.imem_addr, 'hC);
        chk("t6_re3_pc", bus.id_pc, 4);
        next_cycle();

        // Halt at fetch PC 0x10
        bus.halt_req = 1'b1;
        #1;
        chk("t4_h0_req", bus.imem_req, 0);
        chk("t4_h0_pc", bus.id_pc, 8);
        chk("t4_h0_halted", bus.halted, 0);
        next_cycle();
        bus.halt_req = 1'b0;
        #1;
        chk("t4_h1_req", bus.imem_req, 0);
        chk("t4_h1_pc", bus.id_pc, 'hC);
        chk("t4_h1_instr", bus.id_instr, tag('hC));
        chk("t4_h1_halted", bus.halted, 1);
        chk("t4_h1_count", bus.queue_count, 1);
        next_cycle();
        #1;
        chk("t4_h2_valid", bus.id_valid, 0);
        chk("t4_h2_count", bus.queue_count, 0);
        chk("t4_h2_req", bus.imem_req, 0);
        next_cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 9'h080;
        #1;
        chk("t4_redir_req", bus.imem_req, 0);
        next_cycle();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_post_req", bus.imem_req, 0);
        chk("t4_post_halted", bus.halted, 1);
        chk("t4_post_valid", bus.id_valid, 0);
        next_cycle();
        #1;
        chk("t4_post2_req", bus.imem_req, 0);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
